// File: rtl/mc_pkg.sv
// rtl/mc_pkg.sv - shared encodings for the multi-cycle sequencer (optional MC_SEQ_CTRL_HALT_EN)
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EXE  = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b101
    } state_e;

    // Instruction classes seen by the sequencer; selects come separately.
    typedef enum logic [3:0] {
        C_NOP  = 4'd0,
        C_RALU = 4'd1,
        C_IALU = 4'd2,
        C_LW   = 4'd3,
        C_SW   = 4'd4,
        C_BEQ  = 4'd5,
        C_BNE  = 4'd6,
        C_J    = 4'd7,
        C_JAL  = 4'd8,
        C_JR   = 4'd9,
        C_HALT = 4'd10
    } instr_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLL  = 5'd6;

    localparam logic [1:0] BR_PC4   = 2'b00;
    localparam logic [1:0] BR_TGT   = 2'b01;
    localparam logic [1:0] BR_JMP   = 2'b10;
    localparam logic [1:0] BR_RS    = 2'b11;

endpackage

// File: rtl/mc_decode.sv
// rtl/mc_decode.sv - combinational op/func decoder (op 3F becomes HALT under MC_SEQ_CTRL_HALT_EN)
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0]  op_i,
    input  logic [5:0]  func_i,
    output instr_cls_e  cls_o,
    output logic [4:0]  alu_ctrl_o,
    output logic        alu_src_a_o,
    output logic        alu_src_b_o,
    output logic        reg_dst_o,
    output logic        extend_o,
    output logic        mem_to_reg_o
);

    // Decode class and datapath selects; anything unrecognised stays a NOP.
    always_comb begin
        cls_o        = C_NOP;
        alu_ctrl_o   = ALU_ADD;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 1'b0;
        reg_dst_o    = 1'b0;
        extend_o     = 1'b1;
        mem_to_reg_o = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                reg_dst_o = 1'b1;
                case (func_i)
                    FN_ADD: begin cls_o = C_RALU; alu_ctrl_o = ALU_ADD; end
                    FN_SUB: begin cls_o = C_RALU; alu_ctrl_o = ALU_SUB; end
                    FN_AND: begin cls_o = C_RALU; alu_ctrl_o = ALU_AND; end
                    FN_OR:  begin cls_o = C_RALU; alu_ctrl_o = ALU_OR;  end
                    FN_SLT: begin cls_o = C_RALU; alu_ctrl_o = ALU_SLT; end
                    FN_SLL: begin
                        cls_o       = C_RALU;
                        alu_ctrl_o  = ALU_SLL;
                        alu_src_a_o = 1'b1;
                    end
                    FN_JR:  begin cls_o = C_JR; reg_dst_o = 1'b0; end
                    default: reg_dst_o = 1'b0;
                endcase
            end
            OP_ADDI: begin cls_o = C_IALU; alu_src_b_o = 1'b1; end
            OP_SLTI: begin cls_o = C_IALU; alu_src_b_o = 1'b1; alu_ctrl_o = ALU_SLT; end
            OP_ANDI: begin
                cls_o = C_IALU; alu_src_b_o = 1'b1; alu_ctrl_o = ALU_AND; extend_o = 1'b0;
            end
            OP_ORI: begin
                cls_o = C_IALU; alu_src_b_o = 1'b1; alu_ctrl_o = ALU_OR; extend_o = 1'b0;
            end
            OP_LW: begin cls_o = C_LW; alu_src_b_o = 1'b1; mem_to_reg_o = 1'b1; end
            OP_SW: begin cls_o = C_SW; alu_src_b_o = 1'b1; end
            OP_BEQ: begin cls_o = C_BEQ; alu_ctrl_o = ALU_SUB; end
            OP_BNE: begin cls_o = C_BNE; alu_ctrl_o = ALU_SUB; end
            OP_J:   cls_o = C_J;
            OP_JAL: cls_o = C_JAL;
`ifdef MC_SEQ_CTRL_HALT_EN
            OP_HALT: cls_o = C_HALT;
`else
            OP_HALT: cls_o = C_NOP;
`endif
            default: cls_o = C_NOP;
        endcase
    end

endmodule

// File: rtl/mc_seq_ctrl.sv
// rtl/mc_seq_ctrl.sv - multi-cycle control sequencer top (HALT state gated by MC_SEQ_CTRL_HALT_EN)
module mc_seq_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  op,
    input  logic [5:0]  func,
    input  logic        zero,
    output logic        PCWre,
    output logic        IRWre,
    output logic        InstrMemRW,
    output logic        RegWrite,
    output logic        MemWrite,
    output logic        MemtoReg,
    output logic [4:0]  ALUControl,
    output logic [1:0]  Branch,
    output logic        ALUSrcA,
    output logic        ALUSrcB,
    output logic        RegDst,
    output logic        Extend,
    output logic        PCtoReg,
    output logic [2:0]  state
);

    state_e     state_q, state_d;
    instr_cls_e cls;
    logic [4:0] alu_ctrl;
    logic       alu_src_a, alu_src_b, reg_dst, extend, mem_to_reg;
    logic       pc_wre, ir_wre, reg_write, mem_write, pc_to_reg;
    logic [1:0] branch;

    mc_decode u_decode (
        .op_i         (op),
        .func_i       (func),
        .cls_o        (cls),
        .alu_ctrl_o   (alu_ctrl),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .reg_dst_o    (reg_dst),
        .extend_o     (extend),
        .mem_to_reg_o (mem_to_reg)
    );

    // State register; reset parks the sequencer in IF.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IF;
        else      state_q <= state_d;
    end

    // Next state and state-qualified strobes; PCWre fires in the instruction's last state.
    always_comb begin
        state_d   = S_IF;
        pc_wre    = 1'b0;
        ir_wre    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        pc_to_reg = 1'b0;
        branch    = BR_PC4;
        case (state_q)
            S_IF: begin
                ir_wre  = 1'b1;
                state_d = S_ID;
            end
            S_ID: begin
                case (cls)
                    C_J:    begin pc_wre = 1'b1; branch = BR_JMP; end
                    C_JAL:  begin
                        pc_wre = 1'b1; branch = BR_JMP; reg_write = 1'b1; pc_to_reg = 1'b1;
                    end
                    C_JR:   begin pc_wre = 1'b1; branch = BR_RS; end
                    C_NOP:  pc_wre = 1'b1;
                    C_HALT: state_d = S_HALT;
                    default: state_d = S_EXE;
                endcase
            end
            S_EXE: begin
                case (cls)
                    C_LW, C_SW: state_d = S_MEM;
                    C_BEQ: begin pc_wre = 1'b1; branch = zero ? BR_TGT : BR_PC4; end
                    C_BNE: begin pc_wre = 1'b1; branch = zero ? BR_PC4 : BR_TGT; end
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (cls == C_LW) begin
                    state_d = S_WB;
                end else begin
                    mem_write = 1'b1;
                    pc_wre    = 1'b1;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                pc_wre    = 1'b1;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // Reset forces every output low, independent of the clock.
    assign PCWre      = rst & pc_wre;
    assign IRWre      = rst & ir_wre;
    assign InstrMemRW = rst & ir_wre;
    assign RegWrite   = rst & reg_write;
    assign MemWrite   = rst & mem_write;
    assign PCtoReg    = rst & pc_to_reg;
    assign Branch     = rst ? branch : BR_PC4;
    assign MemtoReg   = rst & mem_to_reg;
    assign ALUControl = rst ? alu_ctrl : 5'd0;
    assign ALUSrcA    = rst & alu_src_a;
    assign ALUSrcB    = rst & alu_src_b;
    assign RegDst     = rst & reg_dst;
    assign Extend     = rst & extend;
    assign state      = state_q;

endmodule
